uart_rx_sequencer: RTL

UART_RX_SEQUENCER -- requirements
Module: uart_rx_sequencer

---
 rtl/uart_rx_sequencer_if.sv | 22 ++
 rtl/uart_rx_sequencer.sv | 159 +++++++++++++++
 2 files changed

// File: rtl/uart_rx_sequencer_if.sv
// Consumer-side bus of the UART receiver: held character, status flags and the acknowledge.
// master = receiver, slave = consumer.
interface uart_rx_sequencer_if;
  logic       ack;
  logic       recvStart;
  logic       charRec;
  logic [7:0] dataOut;
  logic       dataValid;
  logic       frameErr;
  logic       overrun;
  logic       parityErr;

  modport master (
    input  ack,
    output recvStart, charRec, dataOut, dataValid, frameErr, overrun, parityErr
  );

  modport slave (
    output ack,
    input  recvStart, charRec, dataOut, dataValid, frameErr, overrun, parityErr
  );
endinterface

// File: rtl/uart_rx_sequencer.sv
// 16x-oversampling UART receiver with a one-character holding register and sticky error flags.
// Optional even-parity bit reception is enabled by defining UART_RX_PARITY_EN.
module uart_rx_sequencer (
  input  logic                clk,
  input  logic                rst,
  input  logic                serialIn,
  input  logic                sampleTick,
  uart_rx_sequencer_if.master rx
);
  localparam int DATA_W = 8;

`ifdef UART_RX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  function automatic logic even_parity(input logic [DATA_W-1:0] d);
    return ^d;
  endfunction

  state_t              state;
  logic                rx_p0, rx_p1;
  logic                rxs;
  logic [3:0]          tick_cnt;
  logic [2:0]          bit_idx;
  logic [DATA_W-1:0]   shift;
  logic [DATA_W-1:0]   data_out;
  logic                data_valid;
  logic                char_rec;
  logic                frame_err;
  logic                overrun_q;
  logic                ack_eff;
  logic                par_ok;
`ifdef UART_RX_PARITY_EN
  logic                par_bad;
  logic                parity_err;
  assign par_ok        = ~par_bad;
  assign rx.parityErr  = parity_err;
`else
  assign par_ok        = 1'b1;
  assign rx.parityErr  = 1'b0;
`endif

  assign rxs     = rx_p1;
  assign ack_eff = rx.ack & data_valid;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_p0      <= 1'b1;
      rx_p1      <= 1'b1;
      state      <= IDLE;
      tick_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      data_out   <= '0;
      data_valid <= 1'b0;
      char_rec   <= 1'b0;
      frame_err  <= 1'b0;
      overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_bad    <= 1'b0;
      parity_err <= 1'b0;
`endif
    end else begin
      // p0 -> p1: two-flop synchronizer on the raw line
      rx_p0    <= serialIn;
      rx_p1    <= rx_p0;
      char_rec <= 1'b0;

      // Acknowledge clears first so that a same-cycle completion or error below wins.
      if (ack_eff) begin
        data_valid <= 1'b0;
        frame_err  <= 1'b0;
        overrun_q  <= 1'b0;
`ifdef UART_RX_PARITY_EN
        parity_err <= 1'b0;
`endif
      end

      case (state)
        IDLE: begin
          if (!rxs) begin
            state    <= START;
            tick_cnt <= '0;
`ifdef UART_RX_PARITY_EN
            par_bad  <= 1'b0;
`endif
          end
        end
        START: begin
          if (sampleTick) begin
            if (tick_cnt == 4'd7) begin
              tick_cnt <= '0;
              bit_idx  <= '0;
              state    <= rxs ? IDLE : DATA;
            end else begin
              tick_cnt <= tick_cnt + 4'd1;
            end
          end
        end
        DATA: begin
          if (sampleTick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              shift   <= {rxs, shift[DATA_W-1:1]};
              bit_idx <= bit_idx + 3'd1;
              if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                state <= PARITY;
`else
                state <= STOP;
`endif
              end
            end
          end
        end
`ifdef UART_RX_PARITY_EN
        PARITY: begin
          if (sampleTick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              state <= STOP;
              if (rxs != even_parity(shift)) begin
                par_bad    <= 1'b1;
                parity_err <= 1'b1;
              end
            end
          end
        end
`endif
        STOP: begin
          if (sampleTick) begin
            tick_cnt <= tick_cnt + 4'd1;
            if (tick_cnt == 4'd15) begin
              state <= IDLE;
              if (!rxs) begin
                frame_err <= 1'b1;
              end else if (par_ok) begin
                data_out   <= shift;
                char_rec   <= 1'b1;
                data_valid <= 1'b1;
                if (data_valid && !rx.ack) overrun_q <= 1'b1;
              end
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign rx.recvStart = (state != IDLE);
  assign rx.charRec   = char_rec;
  assign rx.dataOut   = data_out;
  assign rx.dataValid = data_valid;
  assign rx.frameErr  = frame_err;
  assign rx.overrun   = overrun_q;
endmodule
